// File: rtl/csa_resolve_40.sv
// Carry-save to binary resolver: sum_out = c + s, resolved CHUNK bits per cycle
// with a registered inter-chunk carry and valid/ready handshakes on both sides.
module csa_resolve_40 #(
    parameter int unsigned WIDTH = 40,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] c_in,
    input  logic [WIDTH-1:0] s_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout
);

    localparam int unsigned N    = WIDTH / CHUNK;
    localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CS_W = CHUNK + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   c_q, c_d;
    logic [WIDTH-1:0]   s_q, s_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [CS_W-1:0]    chunk_sum;
    int unsigned        base;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            c_q         <= '0;
            s_q         <= '0;
            sum_q       <= '0;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            c_q         <= c_d;
            s_q         <= s_d;
            sum_q       <= sum_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state, chunk addition and handshake outputs
    always_comb begin
        state_d     = state_q;
        c_d         = c_q;
        s_d         = s_q;
        sum_d       = sum_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        cout_d      = cout_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        base      = CHUNK * 32'(cnt_q);
        chunk_sum = CS_W'(c_q[base +: CHUNK]) + CS_W'(s_q[base +: CHUNK]) + CS_W'(carry_q);

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    c_d        = c_in;
                    s_d        = s_in;
                    cnt_d      = '0;
                    carry_d    = 1'b0;
                    in_ready_d = 1'b0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                sum_d[base +: CHUNK] = chunk_sum[CHUNK-1:0];
                carry_d              = chunk_sum[CHUNK];
                // Counter stops at N-1 so it never leaves its legal range
                if (cnt_q == CW'(N - 1)) begin
                    cout_d      = chunk_sum[CHUNK];
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum_out   = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_csa_resolve_40.sv
// Self-checking bench for csa_resolve_40: directed handshake/boundary steps on a
// CHUNK=8 instance, then random back-to-back traffic on CHUNK=8 and CHUNK=20.
module tb_csa_resolve_40;

    logic        clk = 1'b0;
    logic        rst;
    logic [39:0] c_in, s_in;

    logic        iv0, ir0, ov0, or0, co0;
    logic [39:0] sm0;
    logic        iv1, ir1, ov1, or1, co1;
    logic [39:0] sm1;

    int          errors = 0;
    int          checks = 0;
    logic [40:0] q0[$];
    logic [40:0] q1[$];
    logic [40:0] e0, e1;
    int          recv0 = 0;
    int          recv1 = 0;
    bit          mon_en = 1'b0;
    bit          rnd_or = 1'b0;

    always #5 clk = ~clk;

    csa_resolve_40 #(.WIDTH(40), .CHUNK(8)) d8 (
        .clk(clk), .rst(rst),
        .in_valid(iv0), .in_ready(ir0), .c_in(c_in), .s_in(s_in),
        .out_valid(ov0), .out_ready(or0), .sum_out(sm0), .cout(co0)
    );

    csa_resolve_40 #(.WIDTH(40), .CHUNK(20)) d20 (
        .clk(clk), .rst(rst),
        .in_valid(iv1), .in_ready(ir1), .c_in(c_in), .s_in(s_in),
        .out_valid(ov1), .out_ready(or1), .sum_out(sm1), .cout(co1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: unsigned 41-bit sum of the two vectors
    function automatic logic [40:0] model(input logic [39:0] c, input logic [39:0] s);
        return {1'b0, c} + {1'b0, s};
    endfunction

    // Scoreboard: a result transfers on the edge after a negedge with valid && ready
    always @(negedge clk) begin
        if (mon_en && ov0 && or0) begin
            chk("q0_nonempty", 64'(q0.size() != 0), 64'd1);
            if (q0.size() != 0) begin
                e0 = q0.pop_front();
                chk("rand_chunk8", {23'd0, co0, sm0}, {23'd0, e0});
                recv0++;
            end
        end
        if (mon_en && ov1 && or1) begin
            chk("q1_nonempty", 64'(q1.size() != 0), 64'd1);
            if (q1.size() != 0) begin
                e1 = q1.pop_front();
                chk("rand_chunk20", {23'd0, co1, sm1}, {23'd0, e1});
                recv1++;
            end
        end
    end

    // Random consumer backpressure during the random phase
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rnd_or) begin
                or0 = ($urandom_range(0, 3) != 0);
                or1 = ($urandom_range(0, 3) != 0);
            end
        end
    end

    task automatic accept0(input logic [39:0] c, input logic [39:0] s);
        chk("idle_in_ready", 64'(ir0), 64'd1);
        c_in = c;
        s_in = s;
        iv0  = 1'b1;
        @(posedge clk);
        #1;
        iv0  = 1'b0;
        c_in = '1;
        s_in = '1;
    endtask

    task automatic wait_ov0(output int lat);
        lat = 0;
        while (!ov0 && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic rand_run(input int k, input int n);
        logic [63:0] a, b;
        bit          got;
        for (int i = 0; i < n; i++) begin
            a = {$urandom(), $urandom()};
            b = {$urandom(), $urandom()};
            c_in = a[39:0];
            s_in = b[39:0];
            if ($urandom_range(0, 7) == 0) begin
                s_in = '1;
                c_in = 40'($urandom_range(0, 3));
            end
            if (k == 0) iv0 = 1'b1; else iv1 = 1'b1;
            got = 1'b0;
            for (int w = 0; w < 60 && !got; w++) begin
                @(negedge clk);
                if ((k == 0) ? ir0 : ir1) begin
                    got = 1'b1;
                    if (k == 0) q0.push_back(model(c_in, s_in));
                    else        q1.push_back(model(c_in, s_in));
                end
                @(posedge clk);
                #1;
            end
            if (!got) chk("accept_timeout", 64'(got), 64'd1);
            if (k == 0) iv0 = 1'b0; else iv1 = 1'b0;
        end
        for (int w = 0; w < 100 && ((k == 0) ? q0.size() : q1.size()) != 0; w++) begin
            @(posedge clk);
            #1;
        end
        if (k == 0) begin
            chk("drain8", 64'(q0.size()), 64'd0);
            chk("count8", 64'(recv0), 64'(n));
        end else begin
            chk("drain20", 64'(q1.size()), 64'd0);
            chk("count20", 64'(recv1), 64'(n));
        end
    endtask

    initial begin
        int          lat;
        logic [39:0] held;
        bit          ov_seen;

        rst  = 1'b1;
        iv0  = 1'b0; iv1 = 1'b0;
        or0  = 1'b0; or1 = 1'b0;
        c_in = '0;   s_in = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_in_ready", 64'(ir0), 64'd1);
        chk("rst_out_valid", 64'(ov0), 64'd0);
        chk("rst_sum", 64'(sm0), 64'd0);
        chk("rst_cout", 64'(co0), 64'd0);
        chk("rst_in_ready20", 64'(ir1), 64'd1);

        // Latency and pass-through of s when c is zero; inputs scrambled after accept
        accept0(40'h0, 40'h12_3456_789A);
        wait_ov0(lat);
        chk("latency", 64'(lat), 64'd5);
        chk("pass_sum", 64'(sm0), 64'h12_3456_789A);
        chk("pass_cout", 64'(co0), 64'd0);
        chk("done_in_ready", 64'(ir0), 64'd0);
        or0 = 1'b1;
        @(posedge clk);
        #1;
        or0 = 1'b0;
        chk("deliver_ov_drop", 64'(ov0), 64'd0);
        chk("deliver_in_ready", 64'(ir0), 64'd1);
        chk("deliver_sum_kept", 64'(sm0), 64'h12_3456_789A);

        // Full carry ripple through every chunk
        accept0(40'h00_0000_0002, 40'hFF_FFFF_FFFF);
        wait_ov0(lat);
        chk("ripple_latency", 64'(lat), 64'd5);
        chk("ripple_sum", 64'(sm0), 64'h1);
        chk("ripple_cout", 64'(co0), 64'd1);
        or0 = 1'b1;
        @(posedge clk);
        #1;

        // Zero operands with out_ready already high: delivered on first DONE cycle
        accept0(40'h0, 40'h0);
        wait_ov0(lat);
        chk("zero_latency", 64'(lat), 64'd5);
        chk("zero_sum", 64'(sm0), 64'd0);
        chk("zero_cout", 64'(co0), 64'd0);
        @(posedge clk);
        #1;
        chk("early_ready_ov", 64'(ov0), 64'd0);
        or0 = 1'b0;

        // Backpressure while new data is offered
        accept0(40'h0F_0000_0001, 40'h01_0000_FFFF);
        wait_ov0(lat);
        held = sm0;
        chk("bp_sum", 64'(sm0), 64'h10_0001_0000);
        c_in = 40'hAA_AAAA_AAAA;
        s_in = 40'h55_5555_5555;
        iv0  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("bp_sum_stable", 64'(sm0), 64'(held));
            chk("bp_cout_stable", 64'(co0), 64'd0);
            chk("bp_in_ready", 64'(ir0), 64'd0);
            chk("bp_out_valid", 64'(ov0), 64'd1);
        end
        iv0 = 1'b0;
        or0 = 1'b1;
        @(posedge clk);
        #1;
        or0 = 1'b0;
        ov_seen = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            ov_seen |= ov0;
        end
        chk("bp_no_extra_result", 64'(ov_seen), 64'd0);
        chk("bp_idle_after", 64'(ir0), 64'd1);

        // Reset while BUSY at cnt=2
        accept0(40'h12_3456_789A, 40'h11_1111_1111);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_in_ready", 64'(ir0), 64'd1);
        chk("abort_out_valid", 64'(ov0), 64'd0);
        chk("abort_sum", 64'(sm0), 64'd0);
        chk("abort_cout", 64'(co0), 64'd0);
        ov_seen = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            ov_seen |= ov0;
        end
        chk("abort_no_ov", 64'(ov_seen), 64'd0);

        // Random back-to-back traffic on both chunk sizes
        mon_en = 1'b1;
        rnd_or = 1'b1;
        rand_run(0, 1000);
        rand_run(1, 1000);
        rnd_or = 1'b0;
        mon_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
